// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, error codes,
// FSM state type and the start-time access classification.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FUNCT3   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // Illegal funct3 outranks misalignment, so legality is resolved first.
    function automatic logic [1:0] lsu_check(input logic       is_store,
                                             input logic [2:0] f3,
                                             input logic [1:0] ea_lo);
        logic legal;
        logic misal;
        legal = 1'b0;
        misal = 1'b0;
        case (f3)
            F3_B:    begin legal = 1'b1;      misal = 1'b0;      end
            F3_H:    begin legal = 1'b1;      misal = ea_lo[0];  end
            F3_W:    begin legal = 1'b1;      misal = |ea_lo;    end
            F3_BU:   begin legal = !is_store; misal = 1'b0;      end
            F3_HU:   begin legal = !is_store; misal = ea_lo[0];  end
            default: begin legal = 1'b0;      misal = 1'b0;      end
        endcase
        if (!legal) begin
            return ERR_FUNCT3;
        end else if (misal) begin
            return ERR_MISALIGN;
        end else begin
            return ERR_NONE;
        end
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated store data going out,
// lane selection and sign/zero extension of the returning load word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_f3,
    input  logic [1:0]  i_ea_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_st_data,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: enables follow the access size, data is replicated so any lane works.
    always_comb begin
        o_be      = 4'b0000;
        o_st_data = 32'd0;
        case (i_f3[1:0])
            2'b00: begin
                o_be      = 4'b0001 << i_ea_lo;
                o_st_data = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be      = i_ea_lo[1] ? 4'b1100 : 4'b0011;
                o_st_data = {2{i_wdata[15:0]}};
            end
            2'b10: begin
                o_be      = 4'b1111;
                o_st_data = i_wdata;
            end
            default: begin
                o_be      = 4'b0000;
                o_st_data = 32'd0;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend by funct3.
    always_comb begin
        w_byte    = 8'd0;
        w_half    = i_ea_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        o_ld_data = 32'd0;
        case (i_ea_lo)
            2'b00:   w_byte = i_mem_rdata[7:0];
            2'b01:   w_byte = i_mem_rdata[15:8];
            2'b10:   w_byte = i_mem_rdata[23:16];
            2'b11:   w_byte = i_mem_rdata[31:24];
            default: w_byte = 8'd0;
        endcase
        case (i_f3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_ld_data = i_mem_rdata;
            F3_BU:   o_ld_data = {24'd0, w_byte};
            F3_HU:   o_ld_data = {16'd0, w_half};
            default: o_ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE/REQ/DONE FSM driving a simple
// req/ack memory bus, with optional request timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  lsu_func,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    lsu_state_e  r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [31:0] r_rdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [29:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [2:0]  r_f3;
    logic [1:0]  r_ea_lo;
    logic [31:0] r_cnt;

    logic [31:0] w_ea;
    logic [1:0]  w_code;
    logic [2:0]  w_f3;
    logic [1:0]  w_ea_lo;
    logic [3:0]  w_be;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_data;
    logic        w_timeout;

    assign w_ea      = base + offset;
    assign w_code    = lsu_check(lsu_func[3], lsu_func[2:0], w_ea[1:0]);
    // In IDLE the aligner sees the incoming request; afterwards, the latched one.
    assign w_f3      = (r_state == ST_IDLE) ? lsu_func[2:0] : r_f3;
    assign w_ea_lo   = (r_state == ST_IDLE) ? w_ea[1:0]     : r_ea_lo;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    lsu_align u_align (
        .i_f3        (w_f3),
        .i_ea_lo     (w_ea_lo),
        .i_wdata     (wdata),
        .i_mem_rdata (mem_rdata),
        .o_be        (w_be),
        .o_st_data   (w_st_data),
        .o_ld_data   (w_ld_data)
    );

    // FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_rdata     <= 32'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 30'd0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'd0;
            r_f3        <= 3'd0;
            r_ea_lo     <= 2'd0;
            r_cnt       <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    r_err_code <= ERR_NONE;
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_code != ERR_NONE) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_err      <= 1'b1;
                            r_err_code <= w_code;
                        end else begin
                            r_state     <= ST_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= lsu_func[3];
                            r_mem_addr  <= w_ea[31:2];
                            r_mem_be    <= w_be;
                            r_mem_wdata <= lsu_func[3] ? w_st_data : 32'd0;
                            r_f3        <= lsu_func[2:0];
                            r_ea_lo     <= w_ea[1:0];
                            r_cnt       <= 32'd0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_state   <= ST_DONE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mem_be  <= 4'b0000;
                        r_done    <= 1'b1;
                        if (!r_mem_we) begin
                            r_rdata <= w_ld_data;
                        end
                    end else if (w_timeout) begin
                        r_state    <= ST_DONE;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_be   <= 4'b0000;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    r_err_code <= ERR_NONE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_mem_be  <= 4'b0000;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model sets the
// expected outputs each cycle and one process compares them on the falling edge.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  lsu_func = 4'd0;
    logic [31:0] base = 32'd0;
    logic [31:0] offset = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .lsu_func(lsu_func),
        .base(base), .offset(offset), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    // Expected outputs and care flags
    logic        e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0, e_req = 1'b0, e_we = 1'b0;
    logic [1:0]  e_code = 2'd0;
    logic [31:0] e_rdata = 32'd0, e_wdata = 32'd0;
    logic [29:0] e_addr = 30'd0;
    logic [3:0]  e_be = 4'd0;
    bit          e_full = 1'b0, e_st = 1'b0;
    logic [31:0] m_rdata = 32'd0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---- model of the spec rules ----
    function automatic logic [1:0] m_err(input logic [3:0] f, input logic [31:0] ea);
        bit legal;
        int unsigned n;
        if (f[3]) legal = (f[2:0] inside {3'd0, 3'd1, 3'd2});
        else      legal = (f[2:0] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 2'b10;
        n = 1 << f[1:0];
        if ((ea % n) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] ea);
        int unsigned n, m;
        n = 1 << f3[1:0];
        m = (1 << n) - 1;
        return 4'(m << (ea % 4));
    endfunction

    function automatic logic [31:0] m_st(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 2'd0) return {24'd0, wd[7:0]} * 32'h01010101;
        if (f3[1:0] == 2'd1) return {16'd0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] rd);
        int unsigned n;
        longint v;
        n = 1 << f3[1:0];
        v = longint'(rd >> (8 * (ea % 4)));
        if (n < 4) begin
            v = v & ((longint'(1) << (8 * n)) - 1);
            if (!f3[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        end
        return v[31:0];
    endfunction

    // Falling-edge comparison of every output against the model
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("busy", {31'd0, busy}, {31'd0, e_busy});
            cmp("done", {31'd0, done}, {31'd0, e_done});
            cmp("rdata", rdata, e_rdata);
            cmp("mem_req", {31'd0, mem_req}, {31'd0, e_req});
            cmp("mem_we", {31'd0, mem_we}, {31'd0, e_we});
            cmp("mem_be", {28'd0, mem_be}, {28'd0, e_be});
            if (e_done || e_full) begin
                cmp("err", {31'd0, err}, {31'd0, e_err});
                cmp("err_code", {30'd0, err_code}, {30'd0, e_code});
            end
            if (e_req || e_full) cmp("mem_addr", {2'd0, mem_addr}, {2'd0, e_addr});
            if ((e_req && e_st) || e_full) cmp("mem_wdata", mem_wdata, e_wdata);
        end
    end

    task automatic set_idle(input bit full);
        e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_code = 2'd0;
        e_req = 1'b0; e_we = 1'b0; e_be = 4'd0; e_full = full; e_st = 1'b0;
        e_rdata = m_rdata;
    endtask

    // One transaction; entered and left at posedge+1 of an IDLE cycle
    task automatic run(input logic [3:0] f, input logic [31:0] b, input logic [31:0] o,
                       input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                       input bit noise);
        logic [31:0] ea;
        logic [1:0]  code;
        bit acked;
        ea = b + o;
        code = m_err(f, ea);
        start = 1'b1; lsu_func = f; base = b; offset = o; wdata = wd;
        set_idle(1'b0);
        @(posedge clk); #1;
        start = noise;
        acked = 1'b0;
        if (code != 2'b00) begin
            e_busy = 1'b1; e_done = 1'b1; e_err = 1'b1; e_code = code;
        end else begin
            for (int k = 1; k <= TO; k++) begin
                e_busy = 1'b1; e_done = 1'b0; e_req = 1'b1; e_we = f[3];
                e_addr = ea[31:2]; e_be = m_be(f[2:0], ea); e_st = f[3];
                e_wdata = m_st(f[2:0], wd);
                mem_ack = (k == ack_at);
                mem_rdata = (k == ack_at) ? rd : ~rd;
                @(posedge clk); #1;
                if (k == ack_at) begin
                    acked = 1'b1;
                    break;
                end
            end
            mem_ack = 1'b0;
            if (acked && !f[3]) m_rdata = m_ld(f[2:0], ea, rd);
            e_req = 1'b0; e_we = 1'b0; e_be = 4'd0;
            e_busy = 1'b1; e_done = 1'b1; e_err = !acked;
            e_code = acked ? 2'b00 : 2'b11;
            e_rdata = m_rdata;
        end
        if (noise) begin
            start = 1'b1;
            mem_ack = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0; mem_ack = 1'b0;
        set_idle(1'b0);
    endtask

    initial begin
        // Model pins against hand-derived values
        cmp("pin_sw_be", {28'd0, m_be(3'b010, 32'h1004)}, 32'h0000000F);
        cmp("pin_sh_be", {28'd0, m_be(3'b001, 32'h2002)}, 32'h0000000C);
        cmp("pin_sh_data", m_st(3'b001, 32'h00001234), 32'h12341234);
        cmp("pin_lb", m_ld(3'b000, 32'h1003, 32'h80123456), 32'hFFFFFF80);
        cmp("pin_lbu", m_ld(3'b100, 32'h1003, 32'h80123456), 32'h00000080);
        cmp("pin_err_mis", {30'd0, m_err(4'b0010, 32'h1001)}, 32'd1);
        cmp("pin_err_f3", {30'd0, m_err(4'b0011, 32'h1000)}, 32'd2);

        // Reset state: every output zero
        @(posedge clk); @(posedge clk); #1;
        set_idle(1'b1); e_addr = 30'd0; e_wdata = 32'd0;
        chk_on = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        set_idle(1'b0);

        run(4'b1010, 32'h1000, 32'd4, 32'hDEADBEEF, 32'd0, 1, 1'b0);       // sw
        run(4'b0000, 32'h1000, 32'd3, 32'd0, 32'h80123456, 1, 1'b0);       // lb
        cmp("lb_rdata_lit", rdata, 32'hFFFFFF80);
        run(4'b0100, 32'h1000, 32'd3, 32'd0, 32'h80123456, 2, 1'b0);       // lbu
        cmp("lbu_rdata_lit", rdata, 32'h00000080);
        run(4'b1001, 32'h2000, 32'd2, 32'h00001234, 32'd0, 2, 1'b0);       // sh
        run(4'b0010, 32'h1000, 32'd1, 32'd0, 32'd0, 1, 1'b0);              // lw misaligned
        run(4'b0011, 32'h1000, 32'd0, 32'd0, 32'd0, 1, 1'b0);              // illegal load f3
        run(4'b1100, 32'h1000, 32'd1, 32'd0, 32'd0, 1, 1'b0);              // illegal beats misaligned
        run(4'b1001, 32'h1000, 32'd1, 32'd0, 32'd0, 1, 1'b0);              // sh misaligned
        run(4'b0001, 32'h3000, 32'hFFFFFFFE, 32'd0, 32'h80017FFF, 3, 1'b0); // lh, negative offset
        cmp("lh_rdata_lit", rdata, 32'hFFFF8001);
        run(4'b0101, 32'h0000000E, 32'd2, 32'd0, 32'h1234ABCD, 1, 1'b0);   // lhu
        run(4'b0010, 32'h4000, 32'd8, 32'd0, 32'h55555555, 0, 1'b0);       // timeout, rdata kept
        cmp("timeout_rdata_lit", rdata, 32'h0000ABCD);
        run(4'b0010, 32'h4000, 32'd8, 32'd0, 32'hCAFEF00D, TO, 1'b1);      // ack on last cycle, noise
        run(4'b1000, 32'hFFFFFFFF, 32'd4, 32'h000000A5, 32'd0, 1, 1'b0);   // sb, ea wraps to 3
        run(4'b0000, 32'h10, 32'd1, 32'd0, 32'h0000FE00, 1, 1'b1);         // lb lane 1, noise

        // Reset while mem_req is high, then a late ack
        start = 1'b1; lsu_func = 4'b0010; base = 32'h8000; offset = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        e_busy = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 30'h2000; e_be = 4'hF;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_rdata = 32'd0;
        set_idle(1'b1); e_addr = 30'd0; e_wdata = 32'd0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        set_idle(1'b0);

        run(4'b0010, 32'h100, 32'd4, 32'd0, 32'h01020304, 1, 1'b0);        // lw after reset

        @(negedge clk); #1;
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
